// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
//
// Shared definitions for the CHIP-8 core's display path:
//   - SCREEN_BASE_DEFAULT : default byte address of the 64x32 monochrome screen.
//   - SCREEN_BYTES        : size of the screen region (8 bytes per row x 32 rows).
//   - SCREEN_W/SCREEN_H   : source screen geometry in pixels.
//   - scan_state_t        : scanout sequencer states.
//   - fb_addr()           : framebuffer address of one source byte.
// -----------------------------------------------------------------------------
package chip8_pkg;

    localparam logic [11:0] SCREEN_BASE_DEFAULT = 12'h100;
    localparam int          SCREEN_BYTES        = 256;
    localparam int          SCREEN_W            = 64;
    localparam int          SCREEN_H            = 32;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_FETCH = 2'd1,
        SCAN_EMIT  = 2'd2
    } scan_state_t;

    // Source row is 4*page + row and every row is 8 bytes wide, so the byte
    // offset is simply the concatenation {page, row, group}.
    function automatic logic [11:0] fb_addr(
        input logic [11:0] base,
        input logic [2:0]  page,
        input logic [1:0]  row,
        input logic [2:0]  group
    );
        return base + {4'd0, page, row, group};
    endfunction

endpackage

// File: rtl/scanout_pack.sv
// -----------------------------------------------------------------------------
// scanout_pack
//
// Combinational transpose of four framebuffer bytes (one 8-pixel group from
// four consecutive source rows) into one SSD1306 column byte. Each source row
// is doubled vertically, so row r lands on output bits 2r and 2r+1; bit 0 is
// the top pixel of the page.
//
// Ports:
//   rows  in  4x8  source bytes, rows[r] = source row 4*page + r (MSB = left)
//   pix   in  3    pixel index within the group (column index c >> 1)
//   data  out 8    column byte for the display link
// -----------------------------------------------------------------------------
module scanout_pack (
    input  logic [3:0][7:0] rows,
    input  logic [2:0]      pix,
    output logic [7:0]      data
);

    always_comb begin
        // NOTE: every bit gets a default before the loop so no latch is inferred.
        data = '0;
        for (int r = 0; r < 4; r++) begin
            data[2*r]     = rows[r][3'd7 - pix];
            data[2*r + 1] = rows[r][3'd7 - pix];
        end
    end

endmodule

// File: rtl/screen_scanout.sv
// -----------------------------------------------------------------------------
// screen_scanout
//
// Framebuffer scanout engine. Reads the 64x32 monochrome screen (row-major,
// 8 bytes per row, MSB = leftmost pixel) through a synchronous read port and
// streams it as 1024 bytes in SSD1306 page order, scaled 2x to 128x64.
//
// For every page p (0..7) and 8-pixel group g (0..7) the engine fetches the
// four source rows 4p..4p+3 of group g (5 FETCH cycles), then emits the 16
// display columns of that group (c = 0..15) with a valid/ready handshake.
//
// Parameters:
//   SCREEN_BASE   base byte address of the framebuffer
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         frame request, only looked at in IDLE
//   busy          high while a frame is in progress
//   mem_rd_addr   framebuffer read address
//   mem_rd_data   read data, one cycle after the address
//   out_valid     out_data valid
//   out_ready     downstream accepts on out_valid && out_ready
//   out_data      SSD1306 column byte, bit 0 = top pixel of page
//   out_last      marks the 1024th byte of a frame
//
// Build option:
//   SCANOUT_CONTINUOUS_EN  when defined, the engine restarts at page 0 /
//                          group 0 right after the last byte of a frame and
//                          never returns to IDLE (start ignored after the
//                          first frame). When undefined it returns to IDLE.
// -----------------------------------------------------------------------------
module screen_scanout #(
    parameter logic [11:0] SCREEN_BASE = chip8_pkg::SCREEN_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic [11:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    import chip8_pkg::*;

    scan_state_t     state;
    scan_state_t     state_next;

    logic [2:0]      page;
    logic [2:0]      group;
    logic [3:0]      col;
    logic [2:0]      fetch_cnt;
    logic [3:0][7:0] rows;
    logic [7:0]      pack_data;

    logic            handshake;
    logic            group_done;
    logic            frame_done;

    // -------------------------------------------------------------------------
    // Status and handshake decode
    // -------------------------------------------------------------------------
    assign out_valid  = (state == SCAN_EMIT);
    assign busy       = (state != SCAN_IDLE);
    assign handshake  = out_valid && out_ready;
    assign group_done = handshake && (col == 4'd15);
    assign frame_done = group_done && (page == 3'd7) && (group == 3'd7);
    assign out_last   = out_valid && (page == 3'd7) && (group == 3'd7) && (col == 4'd15);

    // fetch_cnt 0..3 presents row 0..3; at fetch_cnt 4 the address is a
    // don't-care (only the capture of row 3 matters that cycle). In IDLE all
    // indices are zero, so the port rests at SCREEN_BASE.
    assign mem_rd_addr = fb_addr(SCREEN_BASE, page, fetch_cnt[1:0], group);

    // -------------------------------------------------------------------------
    // Column byte formation
    // -------------------------------------------------------------------------
    scanout_pack u_pack (
        .rows (rows),
        .pix  (col[3:1]),
        .data (pack_data)
    );

    // Row buffers are only meaningful in EMIT; gating keeps out_data at zero
    // in every other state, including right after reset.
    assign out_data = out_valid ? pack_data : 8'h00;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            SCAN_IDLE: begin
                if (start) begin
                    state_next = SCAN_FETCH;
                end
            end
            SCAN_FETCH: begin
                if (fetch_cnt == 3'd4) begin
                    state_next = SCAN_EMIT;
                end
            end
            SCAN_EMIT: begin
                if (frame_done) begin
`ifdef SCANOUT_CONTINUOUS_EN
                    state_next = SCAN_FETCH;
`else
                    state_next = SCAN_IDLE;
`endif
                end else if (group_done) begin
                    state_next = SCAN_FETCH;
                end
            end
            default: begin
                state_next = SCAN_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Position counters: page, group, column and fetch step
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register in this block sees the pre-edge values of the others.
            page      <= 3'd0;
            group     <= 3'd0;
            col       <= 4'd0;
            fetch_cnt <= 3'd0;
        end else begin
            unique case (state)
                SCAN_IDLE: begin
                    if (start) begin
                        page      <= 3'd0;
                        group     <= 3'd0;
                        col       <= 4'd0;
                        fetch_cnt <= 3'd0;
                    end
                end
                SCAN_FETCH: begin
                    fetch_cnt <= (fetch_cnt == 3'd4) ? 3'd0 : fetch_cnt + 3'd1;
                end
                SCAN_EMIT: begin
                    if (handshake) begin
                        // col wraps 15 -> 0 on its own; group and page carry
                        // through 7 -> 0, which also rearms the next frame.
                        col <= col + 4'd1;
                        if (col == 4'd15) begin
                            group <= group + 3'd1;
                            if (group == 3'd7) begin
                                page <= page + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    fetch_cnt <= 3'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Row capture: data for the read presented at step k arrives at step k+1
    // -------------------------------------------------------------------------
    // NOTE: the row buffers carry no reset; they are always rewritten before
    // EMIT reads them and out_data is gated outside EMIT.
    always_ff @(posedge clk) begin
        if ((state == SCAN_FETCH) && (fetch_cnt != 3'd0)) begin
            rows[fetch_cnt[1:0] - 2'd1] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_screen_scanout.sv
// -----------------------------------------------------------------------------
// tb_screen_scanout
//
// Directed bench for screen_scanout. A synchronous-read memory model feeds the
// DUT; each scenario task loads a framebuffer pattern, fills a hand-written
// table of expected output bytes, runs a frame and compares inline.
// Build option SCANOUT_CONTINUOUS_EN switches the end-of-frame expectations.
// -----------------------------------------------------------------------------
module tb_screen_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [11:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;

    logic [7:0]  mem [0:4095];
    logic [7:0]  got [0:1023];
    logic [7:0]  expv [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-frame observations filled by run_frame
    int n_got;
    int first_valid;
    int last_k;
    int last_cnt;
    int last_at;
    int busy_low_k;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    screen_scanout #(.SCREEN_BASE(12'h100)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) expv[i] = 8'h00;
    endtask

    // Pulse start, then follow the frame cycle by cycle. k counts negedges
    // after the accepting edge, so k = cycle offset from start acceptance.
    task automatic run_frame(input string name, input int stall_at, input int pulse_at);
        int         k;
        int         stall_left;
        int         extra;
        int         bad;
        int         first_bad;
        bit         stalled;
        bit         done;
        bit         gap_ok;
        bit         second_valid;
        logic [7:0] held_d;
        logic       held_l;

        n_got = 0; first_valid = -1; last_k = -1; last_cnt = 0; last_at = -1; busy_low_k = -1;
        stall_left = 0; stalled = 0; done = 0; gap_ok = 1; second_valid = 0;
        held_d = 8'h00; held_l = 1'b0;
        extra = (stall_at >= 0) ? 5 : 0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (!done && k <= 2000) begin
            start = (k == pulse_at);
            if (last_k < 0) begin
                if (stall_at >= 0 && !stalled && out_valid && n_got == stall_at) begin
                    stalled = 1; stall_left = 5; held_d = out_data; held_l = out_last;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (stall_left < 5) begin
                        n_cmp++;
                        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                            n_bad++;
                            $display("FAIL %s stall_hold k=%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                                     name, k, out_valid, out_data, out_last, held_d, held_l);
                        end
                    end
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid && first_valid < 0) first_valid = k;
                if (out_valid && out_ready) begin
                    if (n_got < 1024) got[n_got] = out_data;
                    if (out_last) begin
                        last_cnt++; last_at = n_got; last_k = k;
                    end
                    n_got++;
                end
            end else begin
`ifdef SCANOUT_CONTINUOUS_EN
                if (k < last_k + 6) begin
                    if (out_valid) gap_ok = 0;
                end else begin
                    second_valid = out_valid;
                    done = 1;
                end
`else
                if (!busy) begin
                    busy_low_k = k;
                    done = 1;
                end
`endif
            end
            if (!done) begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;

        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: frame still running after %0d cycles, required completion", name, k);
        end
        n_cmp++;
        if (n_got != 1024) begin
            n_bad++;
            $display("FAIL %s byte_count: got %0d, required 1024", name, n_got);
        end
        n_cmp++;
        if (last_cnt != 1 || last_at != 1023) begin
            n_bad++;
            $display("FAIL %s out_last: seen %0d times, first at byte %0d, required once at byte 1023", name, last_cnt, last_at);
        end
        n_cmp++;
        if (first_valid != 6) begin
            n_bad++;
            $display("FAIL %s first_valid: cycle %0d, required 6", name, first_valid);
        end
        n_cmp++;
        if (last_k != 1344 + extra) begin
            n_bad++;
            $display("FAIL %s last_handshake: cycle %0d, required %0d", name, last_k, 1344 + extra);
        end
`ifdef SCANOUT_CONTINUOUS_EN
        n_cmp++;
        if (!gap_ok || !second_valid) begin
            n_bad++;
            $display("FAIL %s restart: gap_clean=%0d valid_at_gap_end=%0d, required 1 and 1", name, gap_ok, second_valid);
        end
`else
        n_cmp++;
        if (busy_low_k != 1345 + extra) begin
            n_bad++;
            $display("FAIL %s busy_fall: cycle %0d, required %0d", name, busy_low_k, 1345 + extra);
        end
`endif
        bad = 0; first_bad = -1;
        for (int i = 0; i < 1024; i++) begin
            if (i >= n_got || got[i] !== expv[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s frame_bytes: %0d wrong, first at %0d got %h, required %h",
                     name, bad, first_bad, got[first_bad], expv[first_bad]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 8'h00 || mem_rd_addr !== 12'h100) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b valid=%b last=%b data=%h addr=%h, required 0 0 0 00 100",
                     busy, out_valid, out_last, out_data, mem_rd_addr);
        end
    endtask

    task automatic test_all_zero();
        do_reset();
        clear_mem();
        run_frame("all_zero", -1, -1);
    endtask

    task automatic test_single_pixel();
        do_reset();
        clear_mem();
        mem[12'h100] = 8'h80;
        expv[0] = 8'h03; expv[1] = 8'h03;
        run_frame("single_pixel", -1, -1);
        n_cmp++;
        if (got[0] !== 8'h03 || got[1] !== 8'h03 || got[2] !== 8'h00) begin
            n_bad++;
            $display("FAIL single_pixel_bytes: %h %h %h, required 03 03 00", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_corners();
        do_reset();
        clear_mem();
        mem[12'h118] = 8'h80;   // row 3, column 0
        mem[12'h1FF] = 8'h01;   // row 31, column 63
        expv[0] = 8'hC0; expv[1] = 8'hC0;
        expv[1022] = 8'hC0; expv[1023] = 8'hC0;
        run_frame("corners", -1, -1);
        n_cmp++;
        if (got[0] !== 8'hC0 || got[1] !== 8'hC0) begin
            n_bad++;
            $display("FAIL corner_top_left: %h %h, required C0 C0", got[0], got[1]);
        end
        n_cmp++;
        if (got[1021] !== 8'h00 || got[1022] !== 8'hC0 || got[1023] !== 8'hC0) begin
            n_bad++;
            $display("FAIL corner_bottom_right: %h %h %h, required 00 C0 C0", got[1021], got[1022], got[1023]);
        end
    endtask

    // Pattern: row 0 col 0, row 1 col 1, and all of row 4 group 2
    // (page 1, group 2 -> bytes 160..175 all 0x03).
    task automatic load_pattern();
        clear_mem();
        mem[12'h100] = 8'h80;
        mem[12'h108] = 8'h40;
        mem[12'h122] = 8'hFF;
        expv[0] = 8'h03; expv[1] = 8'h03;
        expv[2] = 8'h0C; expv[3] = 8'h0C;
        for (int i = 160; i < 176; i++) expv[i] = 8'h03;
    endtask

    task automatic test_backpressure();
        do_reset();
        load_pattern();
        run_frame("backpressure", 162, -1);
        n_cmp++;
        if (got[2] !== 8'h0C || got[162] !== 8'h03 || got[176] !== 8'h00) begin
            n_bad++;
            $display("FAIL backpressure_bytes: %h %h %h, required 0C 03 00", got[2], got[162], got[176]);
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        load_pattern();
        run_frame("start_busy", -1, 500);
`ifndef SCANOUT_CONTINUOUS_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL start_busy_idle cycle %0d: busy=%b valid=%b, required 0 0", i, busy, out_valid);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int k;
        int n;
        do_reset();
        load_pattern();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0; n = 0;
        while (n < 300 && k < 2000) begin
            if (out_valid) n++;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (n != 300) begin
            n_bad++;
            $display("FAIL reset_mid_reach: reached %0d bytes, required 300", n);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_abort: valid=%b busy=%b data=%h, required 0 0 00", out_valid, busy, out_data);
        end
        reset = 1'b0;
        @(negedge clk);
        run_frame("after_reset", -1, -1);
        n_cmp++;
        if (got[0] !== 8'h03 || got[2] !== 8'h0C) begin
            n_bad++;
            $display("FAIL after_reset_first: %h %h, required 03 0C", got[0], got[2]);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_pixel();
        test_corners();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/screen_scanout.md
# screen_scanout

Framebuffer scanout engine for the CHIP-8 core. Reads the 64×32 monochrome screen region (256 bytes at 0x100–0x1FF, row-major, 8 bytes per row, MSB = leftmost pixel) through a read port on the shared memory. Streams it as 1024 bytes in SSD1306 page order, scaled 2× to 128×64, to the downstream display link (SPI/I2C OLED driver). Sits between the CPU's memory and the display transport.

## Interface
Parameters:
- SCREEN_BASE, 12'h100, base address of the framebuffer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the last byte handshakes.
- mem_rd_addr  out  12  framebuffer read address.
- mem_rd_data  in  8  read data, valid exactly one cycle after the address (synchronous RAM).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  8  SSD1306 column byte; bit 0 = top pixel of page.
- out_last  out  1  high with the 1024th byte of the frame.

## Operation
- States: IDLE, FETCH, EMIT.
- IDLE -> FETCH on start. Clear page p (0–7) and group g (0–7).
- FETCH: present 4 reads in consecutive cycles, r = 0..3, at address SCREEN_BASE + (4p+r)*8 + g. Capture each mem_rd_data into row[r] one cycle later. After row[3] is captured -> EMIT with column index c = 0.
- EMIT: out_data bit (2r) = bit (2r+1) = row[r][7 − (c>>1)], for r = 0..3. On each handshake c++.
  - After c = 15 handshakes, advance g, then p (carry g 7->0).
  - If p = 7 and g = 7 were just completed -> IDLE; otherwise -> FETCH.
- out_last = EMIT && p==7 && g==7 && c==15.
- Address arithmetic is 12-bit; no wrap is needed (the max address is SCREEN_BASE+0xFF).
- Reset values: state IDLE, busy 0, out_valid 0, out_last 0, out_data 0, mem_rd_addr SCREEN_BASE, p/g/c 0.
- Boundary conditions:
  - start while busy: ignored.
  - reset mid-frame: abort immediately, no partial-frame resume.
  - start held high in IDLE: one frame per acceptance; a new frame begins only after returning to IDLE.
- Memory contents changing mid-frame: no coherency; each byte is read once per frame.

## Timing
- start sampled high at edge N.
  - Reads presented in cycles N+1..N+4.
  - Captures at edges N+2..N+5.
  - out_valid first high in the cycle after edge N+5.
- Per group: 16 EMIT cycles minimum, then a 5-cycle FETCH gap with out_valid low.
- Full frame, with out_ready tied high: 64 × (5 + 16) = 1344 cycles from start to the last handshake.
- Handshake rule: while out_valid && !out_ready, out_data and out_last are held stable and c does not advance.
- out_valid is never dropped without a handshake except on reset.
- busy falls in the cycle after the out_last handshake. start is accepted from that cycle on.

## Configuration
- SCANOUT_CONTINUOUS_EN:
  - Defined: after the out_last handshake, go directly to FETCH with p = g = 0 (back-to-back frames, 5-cycle gap). busy stays high and start is ignored after the first frame.
  - Undefined: return to IDLE and wait for start.

## Structure
- Shared package chip8_pkg holds:
  - SCREEN_BASE default (12'h100), SCREEN_BYTES (256), SCREEN_W (64), SCREEN_H (32);
  - the scanout state enum (IDLE/FETCH/EMIT).
- Sub-module scanout_pack: combinational transpose of row[0..3] plus c[3:1] into out_data; keeps the top level to sequencing only.

## Test plan
- All-zero framebuffer, out_ready=1, start pulse -> exactly 1024 bytes of 0x00; out_last only on byte 1023; busy low 1344+1 cycles after start.
- mem[0x100]=0x80, rest 0 -> bytes 0,1 = 0x03, all others 0x00.
- mem[0x118]=0x80 (row 3, col 0) -> bytes 0,1 = 0xC0; mem[0x1FF]=0x01 (row 31, col 63) -> bytes 1022,1023 = 0xC0.
- Backpressure: out_ready low for 5 cycles mid-group -> out_data/out_last stable for those cycles, no byte lost or duplicated; byte count still 1024.
- reset asserted at byte 300 -> next cycle out_valid 0, busy 0; a new start yields byte 0 first and a full 1024-byte frame.
- start pulsed again while busy -> no effect. With SCANOUT_CONTINUOUS_EN, a second frame starts 5 cycles after the out_last handshake without start.
